// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with a 2-entry skid buffer, flush, bubble gating and a
// forwarding tap from the head entry. in_ready comes from registered state only.
module mem_wb_skid_reg #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEST_W      = 4,
   parameter bit          ZERO_BUBBLE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wb_en,
   input  logic              in_mem_r,
   input  logic [DATA_W-1:0] in_alu_res,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic [DEST_W-1:0] in_dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_wb_en,
   output logic              out_mem_r,
   output logic [DATA_W-1:0] out_alu_res,
   output logic [DATA_W-1:0] out_mem_data,
   output logic [DEST_W-1:0] out_dest,
   output logic              fwd_valid,
   output logic [DEST_W-1:0] fwd_dest,
   output logic [DATA_W-1:0] fwd_value,
   output logic [1:0]        occ
);

   typedef struct packed {
      logic              wb_en;
      logic              mem_r;
      logic [DATA_W-1:0] alu_res;
      logic [DATA_W-1:0] mem_data;
      logic [DEST_W-1:0] dest;
   } entry_t;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e state_q, state_d;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   entry_t in_entry;
   entry_t head_vis;
   logic   push;
   logic   pop;

   assign in_entry = '{wb_en: in_wb_en, mem_r: in_mem_r, alu_res: in_alu_res,
                       mem_data: in_mem_data, dest: in_dest};

   assign in_ready  = (state_q != StTwo);
   assign out_valid = (state_q != StEmpty);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         // Flush wins over any same-cycle push/pop; the pushed entry is dropped.
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (push) begin
                  state_d = StOne;
                  head_d  = in_entry;
               end
            end
            StOne: begin
               if (push && pop) begin
                  head_d = in_entry;
               end else if (push) begin
                  state_d = StTwo;
                  skid_d  = in_entry;
               end else if (pop) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (pop) begin
                  state_d = StOne;
                  head_d  = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      occ = 2'd0;
      unique case (state_q)
         StEmpty: occ = 2'd0;
         StOne:   occ = 2'd1;
         StTwo:   occ = 2'd2;
         default: occ = 2'd0;
      endcase
   end

   assign head_vis = (ZERO_BUBBLE && !out_valid) ? '0 : head_q;

   assign out_wb_en    = head_q.wb_en & out_valid;
   assign out_mem_r    = head_q.mem_r & out_valid;
   assign out_alu_res  = head_vis.alu_res;
   assign out_mem_data = head_vis.mem_data;
   assign out_dest     = head_vis.dest;

   // Only the head entry is forwarded; the skid entry is invisible to EX.
   assign fwd_valid = out_valid & head_q.wb_en;
   assign fwd_dest  = head_vis.dest;
   assign fwd_value = head_q.mem_r ? head_vis.mem_data : head_vis.alu_res;

endmodule
